player_life_ctrl: RTL and testbench
===================================

Name: player_life_ctrl

Overview:
Lives/respawn sequencer for the player block. It tracks remaining lives and, on a hit, runs the death and respawn sequence timed in video frames. It gates the player's move/shoot inputs, drives the player's reset to re-centre it, and flags game over. It sits between the game top (frame tick, start button, collision logic) and the player instance.

Parameters:
start_lives_p, 3, lives loaded on start; legal range 1..max_lives_p
max_lives_p, 7, saturation ceiling for lives_o
death_frames_p, 60, frames spent exploding after a hit; must be >=1
respawn_frames_p, 30, frames the player is held at spawn and blinking; must be >=1
lives_width_p, 3, width of lives_o; must hold max_lives_p

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
frame_i  in  1  one-cycle pulse per video frame
start_i  in  1  start/restart request, level; sampled each cycle
hit_i  in  1  player hit by enemy laser, one-cycle pulse
add_life_i  in  1  bonus-life pulse
player_enable_o  out  1  gates player move/shoot inputs; 1 only in PLAY
player_reset_o  out  1  active-high reset to the player instance
exploding_o  out  1  1 in DYING, selects explosion sprite
visible_o  out  1  player sprite visibility; blinks in RESPAWN
lives_o  out  lives_width_p  remaining lives
game_over_o  out  1  1 in OVER
state_o  out  5  one-hot state {OVER,RESPAWN,DYING,PLAY,IDLE}, bit0=IDLE

Behaviour:
- Reset is asynchronous and active-low, named clk_i / reset_ni. On reset: state IDLE (state_o=5'b00001), lives_o=0, timer=0, visible_o=1, player_reset_o=1, player_enable_o=0, exploding_o=0, game_over_o=0.
- Reset asserted mid-sequence aborts the sequence immediately to the reset values.
- All outputs are registered or decoded from registered state. Effects of an input appear in the cycle after the input is sampled.
- state_o is always exactly one-hot. Unreachable encodings recover to IDLE.
- IDLE: player_reset_o=1. When start_i=1: lives <= start_lives_p, go to PLAY.
- PLAY: player_enable_o=1, player_reset_o=0, visible_o=1.
  - add_life_i: lives <= min(lives+1, max_lives_p).
  - hit_i: lives <= lives-1, saturating at 0; timer <= death_frames_p; go to DYING.
  - hit_i and add_life_i in the same cycle: both are applied (net lives unchanged, but still saturating at max when lives==max); go to DYING.
- DYING: exploding_o=1, player_enable_o=0.
  - hit_i is ignored. add_life_i is still accepted (saturating).
  - Each frame_i decrements timer. On a frame_i with timer==1:
    - lives==0 (including a same-cycle add_life_i on lives==0): go to OVER.
    - Otherwise: timer <= respawn_frames_p, go to RESPAWN.
- RESPAWN: player_reset_o=1, so the player is held at spawn position.
  - visible_o toggles on every frame_i. It is forced to 1 on exit.
  - hit_i is ignored; add_life_i is accepted.
  - On a frame_i with timer==1: go to PLAY. player_reset_o deasserts that same next cycle.
- OVER: game_over_o=1, player_reset_o=1, lives_o=0.
  - When start_i=1: lives <= start_lives_p, go to PLAY.
  - hit_i and add_life_i are ignored.
- start_i is ignored in PLAY, DYING and RESPAWN.
- Timer width is $clog2(max(death_frames_p, respawn_frames_p)+1). The timer never wraps: it is only decremented while nonzero.

Decomposition:
- Package player_pkg:
  - state index constants IDLE_IDX..OVER_IDX
  - state-vector width 5
  - typedef player_state_t (logic [4:0])
- One sub-module, frame_timer: loadable down-counter with load_i, load_val_i, tick_i, and done_o (tick while count==1). Parameterised by width. Same clk_i/reset_ni.

Test Plan:
All scenarios use death_frames_p=2, respawn_frames_p=2, start_lives_p=3, max_lives_p=7.
1. Reset then start_i=1 for one cycle -> next cycle state_o=00010, lives_o=3, player_enable_o=1, player_reset_o=0.
2. In PLAY, hit_i pulse -> state_o=00100, lives_o=2, exploding_o=1, enable=0. After 2 frame_i -> state_o=01000, player_reset_o=1, visible_o toggles 1->0. After 2 more frame_i -> PLAY, visible_o=1.
3. Three hits, each followed by frame_i until PLAY resumes -> after third DYING expires state_o=10000, game_over_o=1, lives_o=0. start_i -> PLAY, lives_o=3.
4. Five add_life_i pulses in PLAY -> lives_o saturates at 7. Simultaneous hit_i+add_life_i at lives_o=7 -> lives_o=7, state DYING (saturation case); at lives_o=4 -> lives_o=4, state DYING.
5. hit_i during DYING or RESPAWN, start_i during PLAY -> no state or lives change. add_life_i in DYING at lives_o=0 -> lives_o=1, then RESPAWN instead of OVER.
6. Assert reset_ni low asynchronously mid-DYING, between clock edges -> outputs immediately take reset values (state_o=00001, lives_o=0). Every cycle the bench checks $countones(state_o)==1.

Source files
------------

// File: rtl/player_pkg.sv
// Shared state encoding for the player lives/respawn sequencer.
package player_pkg;
    localparam int STATE_W     = 5;
    localparam int IDLE_IDX    = 0;
    localparam int PLAY_IDX    = 1;
    localparam int DYING_IDX   = 2;
    localparam int RESPAWN_IDX = 3;
    localparam int OVER_IDX    = 4;

    typedef logic [STATE_W-1:0] player_state_t;

    localparam player_state_t ST_IDLE    = player_state_t'(1 << IDLE_IDX);
    localparam player_state_t ST_PLAY    = player_state_t'(1 << PLAY_IDX);
    localparam player_state_t ST_DYING   = player_state_t'(1 << DYING_IDX);
    localparam player_state_t ST_RESPAWN = player_state_t'(1 << RESPAWN_IDX);
    localparam player_state_t ST_OVER    = player_state_t'(1 << OVER_IDX);
endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; done_o flags the tick that ends the interval.
module frame_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             tick_i,
    output logic             done_o
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count <= '0;
        end else if (load_i) begin
            count <= load_val_i;
        end else if (tick_i && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done_o = tick_i && (count == WIDTH'(1));
endmodule

// File: rtl/player_life_ctrl.sv
// Lives tracking and death/respawn sequencing for the player instance.
module player_life_ctrl
    import player_pkg::*;
#(
    parameter int start_lives_p    = 3,
    parameter int max_lives_p      = 7,
    parameter int death_frames_p   = 60,
    parameter int respawn_frames_p = 30,
    parameter int lives_width_p    = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     frame_i,
    input  logic                     start_i,
    input  logic                     hit_i,
    input  logic                     add_life_i,
    output logic                     player_enable_o,
    output logic                     player_reset_o,
    output logic                     exploding_o,
    output logic                     visible_o,
    output logic [lives_width_p-1:0] lives_o,
    output logic                     game_over_o,
    output logic [STATE_W-1:0]       state_o
);
    localparam int MAX_FRAMES = (death_frames_p > respawn_frames_p) ? death_frames_p : respawn_frames_p;
    localparam int TIMER_W    = $clog2(MAX_FRAMES + 1);
    localparam logic [lives_width_p-1:0] START_LIVES = lives_width_p'(start_lives_p);
    localparam logic [lives_width_p-1:0] MAX_LIVES   = lives_width_p'(max_lives_p);

    player_state_t            state_q;
    logic [lives_width_p-1:0] lives_q;
    logic                     visible_q;
    logic                     timer_load;
    logic [TIMER_W-1:0]       timer_val;
    logic                     timer_done;

    function automatic logic [lives_width_p-1:0] lives_inc(input logic [lives_width_p-1:0] l);
        return (l >= MAX_LIVES) ? MAX_LIVES : l + 1'b1;
    endfunction

    function automatic logic [lives_width_p-1:0] lives_dec(input logic [lives_width_p-1:0] l);
        return (l == '0) ? '0 : l - 1'b1;
    endfunction

    // Timer is armed on a hit in PLAY and re-armed when DYING hands over to RESPAWN.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        if ((state_q == ST_PLAY) && hit_i) begin
            timer_load = 1'b1;
            timer_val  = TIMER_W'(death_frames_p);
        end else if ((state_q == ST_DYING) && timer_done && (lives_q != '0)) begin
            timer_load = 1'b1;
            timer_val  = TIMER_W'(respawn_frames_p);
        end
    end

    frame_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tick_i     (frame_i),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            lives_q   <= '0;
            visible_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_i) begin
                        lives_q <= START_LIVES;
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // Decrement before increment so hit+bonus at the ceiling stays at max.
                    if (hit_i) begin
                        lives_q <= add_life_i ? lives_inc(lives_dec(lives_q)) : lives_dec(lives_q);
                        state_q <= ST_DYING;
                    end else if (add_life_i) begin
                        lives_q <= lives_inc(lives_q);
                    end
                end
                ST_DYING: begin
                    if (add_life_i) lives_q <= lives_inc(lives_q);
                    if (timer_done) begin
                        if (lives_q == '0) begin
                            lives_q <= '0;
                            state_q <= ST_OVER;
                        end else begin
                            state_q <= ST_RESPAWN;
                        end
                    end
                end
                ST_RESPAWN: begin
                    if (add_life_i) lives_q <= lives_inc(lives_q);
                    if (frame_i) begin
                        if (timer_done) begin
                            visible_q <= 1'b1;
                            state_q   <= ST_PLAY;
                        end else begin
                            visible_q <= ~visible_q;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    lives_q   <= '0;
                    visible_q <= 1'b1;
                end
            endcase
        end
    end

    assign state_o         = state_q;
    assign lives_o         = lives_q;
    assign visible_o       = visible_q;
    assign player_enable_o = state_q[PLAY_IDX];
    assign exploding_o     = state_q[DYING_IDX];
    assign game_over_o     = state_q[OVER_IDX];
    assign player_reset_o  = state_q[IDLE_IDX] | state_q[RESPAWN_IDX] | state_q[OVER_IDX];
endmodule

// File: tb/tb_player_life_ctrl.sv
// Directed table-driven bench for player_life_ctrl with short death/respawn intervals.
module tb_player_life_ctrl;
    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b1;
    logic       frame_i = 1'b0;
    logic       start_i = 1'b0;
    logic       hit_i = 1'b0;
    logic       add_life_i = 1'b0;
    logic       player_enable_o, player_reset_o, exploding_o, visible_o, game_over_o;
    logic [2:0] lives_o;
    logic [4:0] state_o;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    localparam logic [4:0] S_IDLE = 5'b00001, S_PLAY = 5'b00010, S_DY = 5'b00100,
                           S_RS = 5'b01000, S_OV = 5'b10000;
    // flags = {enable, player_reset, exploding, visible, game_over}
    localparam logic [4:0] F_IDLE = 5'b01010, F_PLAY = 5'b10010, F_DY = 5'b00110,
                           F_RS1 = 5'b01010, F_RS0 = 5'b01000, F_OV = 5'b01011;

    typedef struct {
        logic [3:0] in;   // {start, hit, add, frame}
        logic [4:0] st;
        logic [2:0] lv;
        logic [4:0] fl;
    } vec_t;
    vec_t vecs[$];

    player_life_ctrl #(
        .start_lives_p(3), .max_lives_p(7), .death_frames_p(2),
        .respawn_frames_p(2), .lives_width_p(3)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .frame_i(frame_i), .start_i(start_i),
        .hit_i(hit_i), .add_life_i(add_life_i), .player_enable_o(player_enable_o),
        .player_reset_o(player_reset_o), .exploding_o(exploding_o), .visible_o(visible_o),
        .lives_o(lives_o), .game_over_o(game_over_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (mon_en) begin
            checks++;
            if ($countones(state_o) != 1) begin
                errors++;
                $display("FAIL onehot t=%0t state_o=%b is not one-hot", $time, state_o);
            end
        end
    end

    task automatic check(input string name, input logic [4:0] st, input logic [2:0] lv,
                         input logic [4:0] fl);
        logic [4:0] afl;
        afl = {player_enable_o, player_reset_o, exploding_o, visible_o, game_over_o};
        checks++;
        if (state_o !== st || lives_o !== lv || afl !== fl) begin
            errors++;
            $display("FAIL %s: got state=%b lives=%0d flags=%b, expected state=%b lives=%0d flags=%b",
                     name, state_o, lives_o, afl, st, lv, fl);
        end
    endtask

    task automatic row(input logic [3:0] in, input logic [4:0] st, input logic [2:0] lv,
                       input logic [4:0] fl);
        vec_t v;
        v.in = in; v.st = st; v.lv = lv; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic step(input logic [3:0] in);
        @(negedge clk_i);
        {start_i, hit_i, add_life_i, frame_i} = in;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // start        hit          add          frame
        row(4'b0000, S_IDLE, 3'd0, F_IDLE);
        row(4'b1000, S_PLAY, 3'd3, F_PLAY);
        row(4'b1000, S_PLAY, 3'd3, F_PLAY);   // start ignored in PLAY
        row(4'b0100, S_DY,   3'd2, F_DY);
        row(4'b0100, S_DY,   3'd2, F_DY);     // hit ignored in DYING
        row(4'b0001, S_DY,   3'd2, F_DY);
        row(4'b1000, S_DY,   3'd2, F_DY);     // start ignored in DYING
        row(4'b0001, S_RS,   3'd2, F_RS1);
        row(4'b0100, S_RS,   3'd2, F_RS1);    // hit ignored in RESPAWN
        row(4'b0001, S_RS,   3'd2, F_RS0);
        row(4'b0001, S_PLAY, 3'd2, F_PLAY);
        row(4'b0100, S_DY,   3'd1, F_DY);
        row(4'b0001, S_DY,   3'd1, F_DY);
        row(4'b0001, S_RS,   3'd1, F_RS1);
        row(4'b0001, S_RS,   3'd1, F_RS0);
        row(4'b0001, S_PLAY, 3'd1, F_PLAY);
        row(4'b0100, S_DY,   3'd0, F_DY);
        row(4'b0010, S_DY,   3'd1, F_DY);     // bonus rescues the last life
        row(4'b0001, S_DY,   3'd1, F_DY);
        row(4'b0001, S_RS,   3'd1, F_RS1);
        row(4'b0001, S_RS,   3'd1, F_RS0);
        row(4'b0001, S_PLAY, 3'd1, F_PLAY);
        row(4'b0100, S_DY,   3'd0, F_DY);
        row(4'b0001, S_DY,   3'd0, F_DY);
        row(4'b0011, S_OV,   3'd0, F_OV);     // late bonus on expiry still ends game
        row(4'b0110, S_OV,   3'd0, F_OV);
        row(4'b1000, S_PLAY, 3'd3, F_PLAY);
        row(4'b0010, S_PLAY, 3'd4, F_PLAY);
        row(4'b0110, S_DY,   3'd4, F_DY);
        row(4'b0001, S_DY,   3'd4, F_DY);
        row(4'b0001, S_RS,   3'd4, F_RS1);
        row(4'b0001, S_RS,   3'd4, F_RS0);
        row(4'b0011, S_PLAY, 3'd5, F_PLAY);
        row(4'b0010, S_PLAY, 3'd6, F_PLAY);
        row(4'b0010, S_PLAY, 3'd7, F_PLAY);
        row(4'b0010, S_PLAY, 3'd7, F_PLAY);   // saturate at max
        row(4'b0110, S_DY,   3'd7, F_DY);     // hit+bonus at max
        row(4'b0010, S_DY,   3'd7, F_DY);
        row(4'b0001, S_DY,   3'd7, F_DY);
        row(4'b0001, S_RS,   3'd7, F_RS1);

        #2 reset_ni = 1'b0;
        #1 check("reset_async", S_IDLE, 3'd0, F_IDLE);
        mon_en = 1'b1;
        @(posedge clk_i); #1;
        check("reset_held", S_IDLE, 3'd0, F_IDLE);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i); #1;
        check("reset_release", S_IDLE, 3'd0, F_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv, vecs[i].fl);
        end

        step(4'b0001); check("seq_rs_blink", S_RS, 3'd7, F_RS0);
        step(4'b0001); check("seq_rs_exit", S_PLAY, 3'd7, F_PLAY);
        step(4'b0100); check("seq_hit", S_DY, 3'd6, F_DY);
        step(4'b0001); check("seq_dy_frame", S_DY, 3'd6, F_DY);
        step(4'b0000);
        #2 reset_ni = 1'b0;
        #1 check("reset_mid_dying", S_IDLE, 3'd0, F_IDLE);
        @(negedge clk_i);
        reset_ni = 1'b1;
        step(4'b0001); check("idle_after_reset", S_IDLE, 3'd0, F_IDLE);
        step(4'b1000); check("restart", S_PLAY, 3'd3, F_PLAY);
        step(4'b0100); check("restart_hit", S_DY, 3'd2, F_DY);
        step(4'b0001); check("restart_dy1", S_DY, 3'd2, F_DY);
        step(4'b0001); check("restart_dy2", S_RS, 3'd2, F_RS1);
        step(4'b0000);
        @(negedge clk_i);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
